// File: rtl/temp_pkg.sv
// Shared definitions for the serial temperature reader: FSM encodings, the
// layout of the 16-bit sensor frame, the fraction clamp value and frame helpers.
package temp_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SHIFT    = 3'd2,
    CS_HOLD  = 3'd3,
    UPDATE   = 3'd4
  } state_e;

  localparam int FRAME_BITS = 16;
  localparam int SIGN_BIT   = 15;
  localparam int INT_MSB    = 14;
  localparam int INT_LSB    = 9;
  localparam int FRAC_MSB   = 8;
  localparam int FRAC_LSB   = 5;
  localparam int PAR_BIT    = 0;

  localparam logic [3:0] FRAC_CLAMP = 4'd9;

  // Even parity over the whole frame, including the parity bit itself.
  function automatic logic frame_parity_ok(input logic [FRAME_BITS-1:0] frame);
    return (^frame) == 1'b0;
  endfunction

  // The tenths digit can never exceed 9; larger field values saturate.
  function automatic logic [3:0] clamp_frac(input logic [3:0] frac);
    if (frac > FRAC_CLAMP) begin
      return FRAC_CLAMP;
    end else begin
      return frac;
    end
  endfunction

endpackage

// File: rtl/sclk_gen.sv
// Serial clock generator: toggles sclk every CLK_DIV clk cycles while enabled,
// starting low. rise_o/fall_o flag the cycle at whose closing edge sclk_o
// goes 0->1 / 1->0. Disabling returns the counter and sclk to zero.
module sclk_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       sclk_q, sclk_d;
  logic       last_s;

  assign last_s = (cnt_q == DIV_LAST);

  // Half-period counter and sclk level next-state.
  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en_i) begin
      cnt_d  = 8'd0;
      sclk_d = 1'b0;
    end else if (last_s) begin
      cnt_d  = 8'd0;
      sclk_d = ~sclk_q;
    end else begin
      cnt_d  = cnt_q + 8'd1;
      sclk_d = sclk_q;
    end
  end

  // Counter and sclk level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 8'd0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;
  assign rise_o = en_i & last_s & ~sclk_q;
  assign fall_o = en_i & last_s & sclk_q;

endmodule

// File: rtl/temp_reader.sv
// Polls a serial temperature sensor: waits POLL_CYCLES in IDLE, asserts chip
// select, clocks in a 16-bit frame MSB first, then loads sign/integer/tenths
// on good parity (valid pulse) or flags the frame (err pulse).
module temp_reader
  import temp_pkg::*;
#(
  parameter int CLK_DIV     = 25,
  parameter int POLL_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       sen_cs_n,
  output logic       sen_sclk,
  input  logic       sen_miso,
  output logic [5:0] temp,
  output logic [3:0] temp_frac,
  output logic       neg,
  output logic       valid,
  output logic       err
);

  localparam logic [31:0] POLL_LAST = 32'(POLL_CYCLES - 1);
  localparam logic [31:0] DIV_LAST  = 32'(CLK_DIV - 1);

  state_e                  state_q, state_d;
  logic [31:0]             cnt_q, cnt_d;
  logic [3:0]              bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic                    cs_n_q, cs_n_d;
  logic [5:0]              temp_q, temp_d;
  logic [3:0]              frac_q, frac_d;
  logic                    neg_q, neg_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;

  logic                    shift_en_s;
  logic                    sclk_s;
  logic                    rise_s;
  logic                    fall_s;

  assign shift_en_s = (state_q == SHIFT);

  sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (shift_en_s),
    .sclk_o (sclk_s),
    .rise_o (rise_s),
    .fall_o (fall_s)
  );

  // Frame sequencing, bit capture and result loading.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    temp_d    = temp_q;
    frac_d    = frac_q;
    neg_d     = neg_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cnt_q == POLL_LAST) begin
          state_d = CS_SETUP;
          cnt_d   = 32'd0;
        end else begin
          cnt_d   = cnt_q + 32'd1;
        end
      end
      CS_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d   = SHIFT;
          cnt_d     = 32'd0;
          bit_cnt_d = 4'd0;
        end else begin
          cnt_d     = cnt_q + 32'd1;
        end
      end
      SHIFT: begin
        // miso has settled since the previous falling edge; capture it as sclk rises.
        if (rise_s) begin
          shift_d = {shift_q[FRAME_BITS-2:0], sen_miso};
        end else begin
          shift_d = shift_q;
        end
        if (fall_s) begin
          if (bit_cnt_q == 4'd15) begin
            state_d   = CS_HOLD;
            bit_cnt_d = 4'd0;
            cnt_d     = 32'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end
      CS_HOLD: begin
        if (cnt_q == DIV_LAST) begin
          state_d = UPDATE;
          cnt_d   = 32'd0;
        end else begin
          cnt_d   = cnt_q + 32'd1;
        end
      end
      UPDATE: begin
        state_d = IDLE;
        cnt_d   = 32'd0;
        if (frame_parity_ok(shift_q)) begin
          temp_d  = shift_q[INT_MSB:INT_LSB];
          frac_d  = clamp_frac(shift_q[FRAC_MSB:FRAC_LSB]);
          neg_d   = shift_q[SIGN_BIT];
          valid_d = 1'b1;
        end else begin
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = 32'd0;
        bit_cnt_d = 4'd0;
        shift_d   = '0;
      end
    endcase
    // Chip select follows the state being entered so it stays registered.
    cs_n_d = !((state_d == CS_SETUP) || (state_d == SHIFT));
  end

  // State, counters, shift register and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 32'd0;
      bit_cnt_q <= 4'd0;
      shift_q   <= '0;
      cs_n_q    <= 1'b1;
      temp_q    <= 6'd0;
      frac_q    <= 4'd0;
      neg_q     <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      cs_n_q    <= cs_n_d;
      temp_q    <= temp_d;
      frac_q    <= frac_d;
      neg_q     <= neg_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign sen_cs_n  = cs_n_q;
  assign sen_sclk  = sclk_s;
  assign temp      = temp_q;
  assign temp_frac = frac_q;
  assign neg       = neg_q;
  assign valid     = valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_temp_reader.sv
// Bench for temp_reader: a sensor model serves queued frames and pushes the
// expected result of each frame into a scoreboard when chip select falls;
// each test task pops and compares when the DUT pulses valid or err.
module tb_temp_reader;

  localparam int CLK_DIV     = 4;
  localparam int POLL_CYCLES = 10;
  localparam int WAIT_BUDGET = 400;

  typedef struct {
    logic       is_err;
    logic [5:0] t;
    logic [3:0] f;
    logic       n;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sen_miso = 1'b0;
  logic       sen_cs_n;
  logic       sen_sclk;
  logic [5:0] temp;
  logic [3:0] temp_frac;
  logic       neg;
  logic       valid;
  logic       err;

  exp_t        exp_q[$];
  logic [15:0] send_q[$];
  int          checks = 0;
  int          errors = 0;
  int          viol = 0;
  int          vcnt = 0;
  int          ecnt = 0;

  logic [15:0] cur_word = 16'h0000;
  int          bit_idx = 0;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;
  logic [5:0]  m_t = 6'd0;
  logic [3:0]  m_f = 4'd0;
  logic        m_n = 1'b0;
  exp_t        sb_e;

  always #5 clk = ~clk;

  temp_reader #(
    .CLK_DIV     (CLK_DIV),
    .POLL_CYCLES (POLL_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sen_cs_n  (sen_cs_n),
    .sen_sclk  (sen_sclk),
    .sen_miso  (sen_miso),
    .temp      (temp),
    .temp_frac (temp_frac),
    .neg       (neg),
    .valid     (valid),
    .err       (err)
  );

  // Sensor model: new frame on chip-select fall, next bit after each sclk fall.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_t = 6'd0;
      m_f = 4'd0;
      m_n = 1'b0;
      sen_miso = 1'b0;
      bit_idx = 0;
    end else if (prev_cs && !sen_cs_n) begin
      if (send_q.size() > 0) cur_word = send_q.pop_front();
      else cur_word = 16'h3261;
      if ((^cur_word) == 1'b0) begin
        m_n = cur_word[15];
        m_t = cur_word[14:9];
        m_f = (cur_word[8:5] > 4'd9) ? 4'd9 : cur_word[8:5];
        sb_e.is_err = 1'b0;
      end else begin
        sb_e.is_err = 1'b1;
      end
      sb_e.t = m_t;
      sb_e.f = m_f;
      sb_e.n = m_n;
      exp_q.push_back(sb_e);
      bit_idx = 15;
      sen_miso = cur_word[15];
    end else if (prev_sclk && !sen_sclk && !sen_cs_n && bit_idx > 0) begin
      bit_idx = bit_idx - 1;
      sen_miso = cur_word[bit_idx];
    end
    prev_cs = sen_cs_n;
    prev_sclk = sen_sclk;
  end

  // Protocol watch over the whole run: pulse exclusivity and sclk idle under cs_n.
  always @(negedge clk) begin
    if (valid && err) viol = viol + 1;
    if (sen_cs_n && sen_sclk) viol = viol + 1;
    if (valid) vcnt = vcnt + 1;
    if (err) ecnt = ecnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_result(output bit got);
    got = 1'b0;
    for (int i = 0; i < WAIT_BUDGET; i++) begin
      @(negedge clk);
      if (valid || err) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    bit   got;
    int   n;
    exp_t e;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sen_cs_n, sen_sclk, temp, temp_frac, neg, valid, err} !== {1'b1, 1'b0, 6'd0, 4'd0, 3'b000}) begin
      errors++;
      $display("FAIL reset_state: got cs_n=%b sclk=%b temp=%0d frac=%0d neg=%b valid=%b err=%b required 1 0 0 0 0 0 0",
               sen_cs_n, sen_sclk, temp, temp_frac, neg, valid, err);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < WAIT_BUDGET; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (!sen_cs_n) break;
    end
    checks++;
    if (n !== POLL_CYCLES) begin
      errors++;
      $display("FAIL first_frame_start: got %0d cycles required %0d", n, POLL_CYCLES);
    end
    wait_result(got);
    checks++;
    if (!got || exp_q.size() == 0) begin
      errors++;
      $display("FAIL first_frame_result: got=%0d queued=%0d required 1 and >=1", got, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({valid, err, temp, temp_frac, neg} !== {1'b1, 1'b0, 6'd25, 4'd3, 1'b0}) begin
        errors++;
        $display("FAIL first_frame_value: got v=%b e=%b %0d.%0d neg=%b required 1 0 25.3 neg=0", valid, err, temp, temp_frac, neg);
      end
    end
  endtask

  task automatic test_basic;
    bit   got;
    exp_t e;
    send_q.push_back(16'h3261);
    wait_result(got);
    checks++;
    if (!got || exp_q.size() == 0) begin
      errors++;
      $display("FAIL basic_result: got=%0d queued=%0d required 1 and >=1", got, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({valid, err, temp, temp_frac, neg} !== {!e.is_err, e.is_err, e.t, e.f, e.n}) begin
        errors++;
        $display("FAIL basic_scoreboard: got %0d.%0d neg=%b required %0d.%0d neg=%b", temp, temp_frac, neg, e.t, e.f, e.n);
      end
      checks++;
      if ({valid, temp, temp_frac, neg} !== {1'b1, 6'd25, 4'd3, 1'b0}) begin
        errors++;
        $display("FAIL basic_value: got v=%b %0d.%0d neg=%b required 1 25.3 neg=0", valid, temp, temp_frac, neg);
      end
      @(negedge clk);
      checks++;
      if (valid !== 1'b0) begin
        errors++;
        $display("FAIL basic_pulse_width: got valid=%b one cycle later required 0", valid);
      end
    end
  endtask

  task automatic test_clamp;
    bit   got;
    exp_t e;
    send_q.push_back(16'h9981);
    wait_result(got);
    checks++;
    if (!got || exp_q.size() == 0) begin
      errors++;
      $display("FAIL clamp_result: got=%0d queued=%0d required 1 and >=1", got, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({valid, err, temp, temp_frac, neg} !== {!e.is_err, e.is_err, e.t, e.f, e.n}) begin
        errors++;
        $display("FAIL clamp_scoreboard: got %0d.%0d neg=%b required %0d.%0d neg=%b", temp, temp_frac, neg, e.t, e.f, e.n);
      end
      checks++;
      if ({valid, temp, temp_frac, neg} !== {1'b1, 6'd12, 4'd9, 1'b1}) begin
        errors++;
        $display("FAIL clamp_value: got v=%b %0d.%0d neg=%b required 1 12.9 neg=1", valid, temp, temp_frac, neg);
      end
    end
  endtask

  task automatic test_bad_parity;
    bit   got;
    exp_t e;
    send_q.push_back(16'h3261);
    send_q.push_back(16'h3260);
    wait_result(got);
    checks++;
    if (!got || exp_q.size() == 0) begin
      errors++;
      $display("FAIL parity_good_result: got=%0d queued=%0d required 1 and >=1", got, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({valid, err, temp, temp_frac, neg} !== {1'b1, 1'b0, 6'd25, 4'd3, 1'b0}) begin
        errors++;
        $display("FAIL parity_good_value: got v=%b e=%b %0d.%0d neg=%b required 1 0 25.3 neg=0", valid, err, temp, temp_frac, neg);
      end
    end
    wait_result(got);
    checks++;
    if (!got || exp_q.size() == 0) begin
      errors++;
      $display("FAIL parity_bad_result: got=%0d queued=%0d required 1 and >=1", got, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({valid, err, temp, temp_frac, neg} !== {!e.is_err, e.is_err, e.t, e.f, e.n}) begin
        errors++;
        $display("FAIL parity_bad_scoreboard: got v=%b e=%b %0d.%0d required v=%b e=%b %0d.%0d", valid, err, temp, temp_frac, !e.is_err, e.is_err, e.t, e.f);
      end
      checks++;
      if ({valid, err, temp, temp_frac, neg} !== {1'b0, 1'b1, 6'd25, 4'd3, 1'b0}) begin
        errors++;
        $display("FAIL parity_bad_value: got v=%b e=%b %0d.%0d neg=%b required 0 1 25.3 neg=0", valid, err, temp, temp_frac, neg);
      end
      @(negedge clk);
      checks++;
      if ({valid, err, temp, temp_frac, neg} !== {1'b0, 1'b0, 6'd25, 4'd3, 1'b0}) begin
        errors++;
        $display("FAIL parity_bad_hold: got v=%b e=%b %0d.%0d neg=%b required 0 0 25.3 neg=0", valid, err, temp, temp_frac, neg);
      end
    end
  endtask

  task automatic test_neg_zero;
    bit   got;
    exp_t e;
    send_q.push_back(16'h80A1);
    wait_result(got);
    checks++;
    if (!got || exp_q.size() == 0) begin
      errors++;
      $display("FAIL negzero_result: got=%0d queued=%0d required 1 and >=1", got, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({valid, err, temp, temp_frac, neg} !== {1'b1, 1'b0, 6'd0, 4'd5, 1'b1}) begin
        errors++;
        $display("FAIL negzero_value: got v=%b e=%b %0d.%0d neg=%b required 1 0 0.5 neg=1", valid, err, temp, temp_frac, neg);
      end
    end
  endtask

  task automatic test_timing;
    bit   got;
    bit   done;
    int   low, high, rises, period, bad, last_rise, consumed;
    logic ps, pc;
    exp_t e;
    got = 1'b0;
    for (int i = 0; i < WAIT_BUDGET; i++) begin
      @(negedge clk);
      if (!sen_cs_n) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL timing_start: got no chip-select fall required one within %0d cycles", WAIT_BUDGET);
    end
    low = 1; high = 0; rises = 0; period = 0; bad = 0; last_rise = 0; consumed = 0;
    done = 1'b0; ps = sen_sclk; pc = sen_cs_n;
    for (int i = 1; i < 1000 && !done; i++) begin
      @(negedge clk);
      period = i;
      if (!sen_cs_n && pc) begin
        done = 1'b1;
      end else begin
        if (!sen_cs_n) low++;
        if (sen_sclk) high++;
        if (sen_sclk && !ps) begin
          rises++;
          if (rises > 1 && (i - last_rise) != 2 * CLK_DIV) bad++;
          last_rise = i;
        end
        if ((valid || err) && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          consumed++;
          checks++;
          if ({valid, err, temp, temp_frac, neg} !== {!e.is_err, e.is_err, e.t, e.f, e.n}) begin
            errors++;
            $display("FAIL timing_scoreboard: got %0d.%0d neg=%b required %0d.%0d neg=%b", temp, temp_frac, neg, e.t, e.f, e.n);
          end
        end
      end
      ps = sen_sclk;
      pc = sen_cs_n;
    end
    checks++;
    if ({done, period} !== {1'b1, 32'd147}) begin
      errors++;
      $display("FAIL frame_period: got done=%0d period=%0d required done=1 period=147", done, period);
    end
    checks++;
    if (low !== 132) begin
      errors++;
      $display("FAIL cs_low_cycles: got %0d required 132", low);
    end
    checks++;
    if ({rises, high, bad, consumed} !== {32'd16, 32'd64, 32'd0, 32'd1}) begin
      errors++;
      $display("FAIL sclk_periods: got rises=%0d high=%0d bad_spacing=%0d results=%0d required 16 64 0 1", rises, high, bad, consumed);
    end
  endtask

  task automatic test_reset_midframe;
    bit   got;
    int   rises, n, pulses_before;
    logic ps;
    exp_t e;
    rises = 0;
    ps = sen_sclk;
    for (int i = 0; i < WAIT_BUDGET && rises < 8; i++) begin
      @(negedge clk);
      if (sen_sclk && !ps && !sen_cs_n) rises++;
      ps = sen_sclk;
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rises, sen_cs_n, sen_sclk, temp, temp_frac, neg, valid, err} !== {32'd8, 1'b1, 1'b0, 6'd0, 4'd0, 3'b000}) begin
      errors++;
      $display("FAIL midframe_reset_state: got rises=%0d cs_n=%b sclk=%b temp=%0d frac=%0d neg=%b v=%b e=%b required 8 1 0 0 0 0 0 0",
               rises, sen_cs_n, sen_sclk, temp, temp_frac, neg, valid, err);
    end
    pulses_before = vcnt + ecnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < WAIT_BUDGET; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (!sen_cs_n) break;
    end
    checks++;
    if (n !== POLL_CYCLES) begin
      errors++;
      $display("FAIL midframe_restart: got %0d cycles required %0d", n, POLL_CYCLES);
    end
    checks++;
    if ((vcnt + ecnt) !== pulses_before) begin
      errors++;
      $display("FAIL midframe_no_pulse: got %0d pulses after abort required 0", vcnt + ecnt - pulses_before);
    end
    wait_result(got);
    checks++;
    if (!got || exp_q.size() == 0) begin
      errors++;
      $display("FAIL midframe_next_result: got=%0d queued=%0d required 1 and >=1", got, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({valid, err, temp, temp_frac, neg} !== {!e.is_err, e.is_err, e.t, e.f, e.n}) begin
        errors++;
        $display("FAIL midframe_next_value: got %0d.%0d neg=%b required %0d.%0d neg=%b", temp, temp_frac, neg, e.t, e.f, e.n);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit          got;
    logic [15:0] w;
    exp_t        e;
    for (int k = 0; k < 4; k++) begin
      w = 16'($urandom);
      send_q.push_back(w);
      wait_result(got);
      checks++;
      if (!got || exp_q.size() == 0) begin
        errors++;
        $display("FAIL b2b_result[%0d]: got=%0d queued=%0d required 1 and >=1", k, got, exp_q.size());
      end else begin
        e = exp_q.pop_front();
        checks++;
        if ({valid, err, temp, temp_frac, neg} !== {!e.is_err, e.is_err, e.t, e.f, e.n}) begin
          errors++;
          $display("FAIL b2b_value[%0d] word=%h: got v=%b e=%b %0d.%0d neg=%b required v=%b e=%b %0d.%0d neg=%b",
                   k, w, valid, err, temp, temp_frac, neg, !e.is_err, e.is_err, e.t, e.f, e.n);
        end
      end
    end
  endtask

  task automatic test_checker;
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL protocol_watch: got %0d violations required 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_bad_parity();
    test_neg_zero();
    test_timing();
    test_reset_midframe();
    test_back_to_back();
    test_checker();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/temp_reader.md
TEMP_READER -- requirements
Module: temp_reader

Interface
REQ-001 Parameter CLK_DIV, default 25: clk cycles per sclk half-period; legal range 2..255.
REQ-002 Parameter POLL_CYCLES, default 50_000_000: clk cycles spent in IDLE between frames; legal range >= 2.
REQ-003 clk  input  1  system clock; one clock domain only.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 sen_cs_n  output  1  sensor chip select, active-low.
REQ-006 sen_sclk  output  1  sensor serial clock; idles low.
REQ-007 sen_miso  input  1  sensor serial data, MSB first.
REQ-008 temp  output  6  integer magnitude of the last good reading.
REQ-009 temp_frac  output  4  tenths digit of the last good reading, range 0..9.
REQ-010 neg  output  1  sign of the last good reading; 1 means negative.
REQ-011 valid  output  1  one-cycle pulse when temp/temp_frac/neg update.
REQ-012 err  output  1  one-cycle pulse when a frame fails parity.

Function
REQ-013 FSM states SHALL be IDLE, CS_SETUP, SHIFT, CS_HOLD, UPDATE; every other encoding SHALL return to IDLE.
REQ-014 IDLE: sen_cs_n=1, sen_sclk=0; the poll counter counts POLL_CYCLES clk cycles, then the FSM moves to CS_SETUP.
REQ-015 CS_SETUP: sen_cs_n=0, sen_sclk=0 for CLK_DIV cycles, then SHIFT.
REQ-016 SHIFT: sen_sclk toggles every CLK_DIV cycles, starting low, for 16 full periods (32*CLK_DIV cycles); sen_cs_n stays 0.
REQ-017 sen_miso SHALL be sampled in the clk cycle where sen_sclk goes 0->1; it is shifted into a 16-bit register, MSB first.
REQ-018 After the 16th falling edge (sen_sclk back to 0), the FSM moves to CS_HOLD: sen_cs_n=1 for CLK_DIV cycles, then UPDATE.
REQ-019 Frame format: bit15 sign; bits14:9 integer; bits8:5 fraction; bits4:1 reserved and ignored; bit0 even parity (XOR of bits 15:0 == 0 means good).
REQ-020 UPDATE lasts 1 cycle; on good parity, outputs load on the next clk edge and valid pulses high for exactly that 1 cycle.
REQ-021 Fraction clamp: a fraction field > 9 SHALL load temp_frac=9; otherwise the field loads unchanged.
REQ-022 On bad parity: err pulses for 1 cycle; temp, temp_frac and neg hold their previous values; valid stays 0.
REQ-023 valid and err SHALL never be high in the same cycle.
REQ-024 UPDATE returns to IDLE with the poll counter cleared; frame period = POLL_CYCLES + 34*CLK_DIV + 1 cycles.
REQ-025 A sign=1, integer=0 frame is legal and SHALL load neg=1 unmodified.
REQ-026 sen_miso is not synchronised; the sensor drives it from sen_sclk falling edges, and at least CLK_DIV-1 cycles of settling are guaranteed.

Reset
REQ-027 Asserting rst_n low SHALL immediately force: state=IDLE, sen_cs_n=1, sen_sclk=0, temp=0, temp_frac=0, neg=0, valid=0, err=0, all counters and the shift register to 0.
REQ-028 Reset mid-frame SHALL abort the frame without an output update; after release, the first frame starts POLL_CYCLES cycles later.

Structure
REQ-029 FSM state encodings, frame bit positions and the clamp value 9 SHALL live in shared package temp_pkg, for reuse by monitor-side logic.
REQ-030 One sub-module, sclk_gen, SHALL implement the CLK_DIV half-period counter and emit the sclk level plus one-cycle rise/fall strobes; everything else stays in temp_reader.

Verification
REQ-031 Sensor model returns 0x3261 -> valid pulse; temp=25, temp_frac=3, neg=0.
REQ-032 Sensor model returns 0x9981 (fraction field 12) -> valid pulse; temp=12, temp_frac=9 (clamped), neg=1.
REQ-033 Good 0x3261, then 0x3260 (bad parity) -> err pulse on the second frame; outputs stay 25/3/0; valid stays 0.
REQ-034 CLK_DIV=4, POLL_CYCLES=10 -> exactly 16 sclk periods of 8 cycles each while sen_cs_n=0; sen_cs_n low for 34*4-4=132 cycles; frame period 147 cycles.
REQ-035 rst_n pulsed low during the 8th sclk period -> same cycle: sen_cs_n=1, sen_sclk=0, outputs 0; no valid or err; the next frame starts 10 cycles after release.
REQ-036 Checker over all tests: valid and err never coincide; sen_sclk is 0 whenever sen_cs_n=1.
